beta_io_bus: RTL and testbench

Parametrised memory-mapped I/O block on the Beta data bus: N general input ports, M general output ports, and a single-channel SPI master, all word-addressed. It sits between the Beta memory interface (addr/din/mwe/dout) and the laser projector's board-level pins (DAC SPI, switches, galvo enables). It adds a real SPI engine and a synchronous reset, and supports any port count within the map.

---
 rtl/beta_io_bus_pkg.sv | 34 +++
 rtl/beta_io_bus_if.sv | 38 +++
 rtl/beta_io_bus_spi_master_core.sv | 134 +++++++++++++
 rtl/beta_io_bus.sv | 148 ++++++++++++++
 tb/tb_beta_io_bus.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/beta_io_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : beta_io_pkg
// Purpose  : Shared constants for the Beta I/O bus block: register indices,
//            SPI_CFG field layout and SPI master state encoding.
// Revision : 1.0  initial release
// ============================================================================
package beta_io_pkg;

    // Register indices (addr[15:0])
    localparam logic [15:0] IN_BASE   = 16'h0000;
    localparam logic [15:0] OUT_BASE  = 16'h0008;
    localparam logic [15:0] SPI_CFG   = 16'h0010;
    localparam logic [15:0] SPI_START = 16'h0011;
    localparam logic [15:0] SPI_TX    = 16'h0012;
    localparam logic [15:0] SPI_RX    = 16'h0013;

    // SPI_CFG fields
    localparam int CFG_DIV_LSB = 0;
    localparam int CFG_DIV_W   = 8;
    localparam int CFG_LEN_LSB = 8;
    localparam int CFG_LEN_W   = 5;
    localparam int CFG_W       = CFG_LEN_LSB + CFG_LEN_W;

    // SPI master state encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/beta_io_bus_if.sv
`default_nettype none
// ============================================================================
// Module   : beta_io_bus_if
// Purpose  : Bundles the Beta memory-side bus and the board-level pins of
//            beta_io_bus.
//            slave  : the I/O block (receives addr/din/mwe, pins in)
//            master : the Beta side / environment
// Ports    : addr, din, mwe, dout, in_ports, out_ports,
//            spi_miso, spi_csn, spi_sclk, spi_mosi, spi_busy
// Revision : 1.0  initial release
// ============================================================================
interface beta_io_bus_if #(
    parameter int N_IN  = 2,
    parameter int N_OUT = 2
);
    logic [31:0]         addr;
    logic [31:0]         din;
    logic                mwe;
    logic [31:0]         dout;
    logic [32*N_IN-1:0]  in_ports;
    logic [32*N_OUT-1:0] out_ports;
    logic                spi_miso;
    logic                spi_csn;
    logic                spi_sclk;
    logic                spi_mosi;
    logic                spi_busy;

    modport slave (
        input  addr, din, mwe, in_ports, spi_miso,
        output dout, out_ports, spi_csn, spi_sclk, spi_mosi, spi_busy
    );

    modport master (
        output addr, din, mwe, in_ports, spi_miso,
        input  dout, out_ports, spi_csn, spi_sclk, spi_mosi, spi_busy
    );
endinterface
`default_nettype wire

// File: rtl/beta_io_bus_spi_master_core.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_core
// Purpose  : Single-channel SPI master, mode 0, MSB first, 1..32 bit frames.
//            Half-period = div+1 clocks. Frame = SETUP (1 half-period),
//            SHIFT (2*(len+1) half-periods), HOLD (1 half-period).
// Ports    : clk, reset, start, tx[31:0], len[4:0], div[7:0], miso  (in)
//            busy, rx[31:0], csn, sclk, mosi                      (out)
// Revision : 1.0  initial release
// ============================================================================
module spi_master_core
    import beta_io_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] tx,
    input  logic [4:0]  len,
    input  logic [7:0]  div,
    input  logic        miso,
    output logic        busy,
    output logic [31:0] rx,
    output logic        csn,
    output logic        sclk,
    output logic        mosi
);
    spi_state_t  r_state;
    logic [7:0]  r_cnt;
    logic [7:0]  r_div;
    logic [4:0]  r_len;
    logic [5:0]  r_hp;
    logic [31:0] r_tx_sr;
    logic [31:0] r_rx_sr;
    logic [31:0] r_rx;
    logic        r_busy;
    logic        r_csn;
    logic        r_sclk;
    logic        r_mosi;

    logic [31:0] w_tx_next;
    logic [5:0]  w_hp_last;
    logic        w_hp_end;

    assign w_tx_next = {r_tx_sr[30:0], 1'b0};
    // SHIFT half-periods are numbered 0..2*len+1; even ones are sclk high.
    assign w_hp_last = {r_len, 1'b1};
    assign w_hp_end  = (r_cnt == 8'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_div   <= 8'd0;
            r_len   <= 5'd0;
            r_hp    <= 6'd0;
            r_tx_sr <= 32'd0;
            r_rx_sr <= 32'd0;
            r_rx    <= 32'd0;
            r_busy  <= 1'b0;
            r_csn   <= 1'b1;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= SETUP;
                        r_tx_sr <= tx;
                        r_len   <= len;
                        r_div   <= div;
                        r_cnt   <= div;
                        r_hp    <= 6'd0;
                        r_rx_sr <= 32'd0;
                        r_busy  <= 1'b1;
                        r_csn   <= 1'b0;
                        r_mosi  <= tx[len];
                    end
                end
                SETUP: begin
                    if (w_hp_end) begin
                        // First rising edge: sample the first bit.
                        r_state <= SHIFT;
                        r_cnt   <= r_div;
                        r_hp    <= 6'd0;
                        r_sclk  <= 1'b1;
                        r_rx_sr <= {r_rx_sr[30:0], miso};
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                SHIFT: begin
                    if (w_hp_end) begin
                        r_cnt <= r_div;
                        if (r_hp == w_hp_last) begin
                            r_state <= HOLD;
                        end else begin
                            r_hp <= r_hp + 6'd1;
                            if (r_sclk) begin
                                r_sclk  <= 1'b0;
                                r_tx_sr <= w_tx_next;
                                r_mosi  <= w_tx_next[r_len];
                            end else begin
                                r_sclk  <= 1'b1;
                                r_rx_sr <= {r_rx_sr[30:0], miso};
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                HOLD: begin
                    if (w_hp_end) begin
                        r_state <= IDLE;
                        r_csn   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_mosi  <= 1'b0;
                        r_rx    <= r_rx_sr;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign rx   = r_rx;
    assign csn  = r_csn;
    assign sclk = r_sclk;
    assign mosi = r_mosi;

endmodule
`default_nettype wire

// File: rtl/beta_io_bus.sv
`default_nettype none
// ============================================================================
// Module   : beta_io_bus
// Purpose  : Memory-mapped I/O on the Beta data bus: N_IN input ports,
//            N_OUT output ports and one SPI master. Does address decode,
//            port/config registers and the registered read mux.
// Ports    : clk, reset (sync, active-high), bus (beta_io_bus_if.slave)
// Options  : BETA_IO_INPUT_SYNC_EN - 2-flop synchronizers on in_ports and
//            spi_miso (adds 2 cycles to IN reads).
// Revision : 1.0  initial release
// ============================================================================
module beta_io_bus
    import beta_io_pkg::*;
#(
    parameter int          N_IN        = 2,
    parameter int          N_OUT       = 2,
    parameter logic [15:0] BASE_HI     = 16'h0000,
    parameter logic [7:0]  SPI_DIV_RST = 8'd4
) (
    input  logic         clk,
    input  logic         reset,
    beta_io_bus_if.slave bus
);
    localparam logic [CFG_W-1:0] c_CFG_RST = {5'd7, SPI_DIV_RST};

    logic                w_hit;
    logic [15:0]         w_idx;
    logic                w_wr;
    logic [32*N_IN-1:0]  w_in;
    logic                w_miso;
    logic [32*N_OUT-1:0] r_out;
    logic [CFG_W-1:0]    r_cfg;
    logic [31:0]         r_tx;
    logic [31:0]         r_dout;
    logic [31:0]         w_rdata;
    logic                w_busy;
    logic                w_start;
    logic [31:0]         w_rx;
    logic                w_csn;
    logic                w_sclk;
    logic                w_mosi;

    assign w_hit = (bus.addr[31:16] == BASE_HI);
    assign w_idx = bus.addr[15:0];
    assign w_wr  = bus.mwe & w_hit;

`ifdef BETA_IO_INPUT_SYNC_EN
    logic [32*N_IN-1:0] r_in_s1;
    logic [32*N_IN-1:0] r_in_s2;
    logic               r_miso_s1;
    logic               r_miso_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_s1   <= '0;
            r_in_s2   <= '0;
            r_miso_s1 <= 1'b0;
            r_miso_s2 <= 1'b0;
        end else begin
            r_in_s1   <= bus.in_ports;
            r_in_s2   <= r_in_s1;
            r_miso_s1 <= bus.spi_miso;
            r_miso_s2 <= r_miso_s1;
        end
    end

    assign w_in   = r_in_s2;
    assign w_miso = r_miso_s2;
`else
    assign w_in   = bus.in_ports;
    assign w_miso = bus.spi_miso;
`endif

    // START while busy is dropped here as well as in the core.
    assign w_start = w_wr && (w_idx == SPI_START) && !w_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out  <= '0;
            r_cfg  <= c_CFG_RST;
            r_tx   <= 32'd0;
            r_dout <= 32'd0;
        end else begin
            // Read mux sees pre-write register values: read-during-write
            // returns the old value.
            r_dout <= w_rdata;
            for (int k = 0; k < N_OUT; k++) begin
                if (w_wr && (w_idx == OUT_BASE + 16'(k))) begin
                    r_out[32*k +: 32] <= bus.din;
                end
            end
            if (w_wr && (w_idx == SPI_CFG) && !w_busy) begin
                r_cfg <= bus.din[CFG_W-1:0];
            end
            // TX is writable while busy; the core latched its copy at START.
            if (w_wr && (w_idx == SPI_TX)) begin
                r_tx <= bus.din;
            end
        end
    end

    always_comb begin
        w_rdata = 32'd0;
        if (w_hit) begin
            for (int k = 0; k < N_IN; k++) begin
                if (w_idx == IN_BASE + 16'(k)) begin
                    w_rdata = w_in[32*k +: 32];
                end
            end
            for (int k = 0; k < N_OUT; k++) begin
                if (w_idx == OUT_BASE + 16'(k)) begin
                    w_rdata = r_out[32*k +: 32];
                end
            end
            case (w_idx)
                SPI_CFG:   w_rdata = 32'(r_cfg);
                SPI_START: w_rdata = {31'd0, w_busy};
                SPI_TX:    w_rdata = r_tx;
                SPI_RX:    w_rdata = w_rx;
                default:   ;
            endcase
        end
    end

    spi_master_core u_spi (
        .clk   (clk),
        .reset (reset),
        .start (w_start),
        .tx    (r_tx),
        .len   (r_cfg[CFG_LEN_LSB +: CFG_LEN_W]),
        .div   (r_cfg[CFG_DIV_LSB +: CFG_DIV_W]),
        .miso  (w_miso),
        .busy  (w_busy),
        .rx    (w_rx),
        .csn   (w_csn),
        .sclk  (w_sclk),
        .mosi  (w_mosi)
    );

    assign bus.dout      = r_dout;
    assign bus.out_ports = r_out;
    assign bus.spi_busy  = w_busy;
    assign bus.spi_csn   = w_csn;
    assign bus.spi_sclk  = w_sclk;
    assign bus.spi_mosi  = w_mosi;

endmodule
`default_nettype wire

// File: tb/tb_beta_io_bus.sv
`default_nettype none
// ============================================================================
// Module   : tb_beta_io_bus
// Purpose  : Self-checking bench for beta_io_bus (default build). Register
//            map and SPI frames are checked against a register-array model
//            and frame arithmetic derived from the register map and timing.
// Revision : 1.0  initial release
// ============================================================================
module tb_beta_io_bus;
    localparam logic [15:0] BASE = 16'h0000;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    int   csn_falls;
    logic prev_csn;
    logic loop_en;
    logic miso_val;

    // Reference model state
    logic [31:0] in_m  [2];
    logic [31:0] out_m [2];
    logic [31:0] cfg_m;
    logic [31:0] tx_m;
    logic [31:0] rx_m;
    logic        busy_m;

    beta_io_bus_if #(.N_IN(2), .N_OUT(2)) bus_if ();

    beta_io_bus #(
        .N_IN        (2),
        .N_OUT       (2),
        .BASE_HI     (BASE),
        .SPI_DIV_RST (8'd4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    assign bus_if.spi_miso = loop_en ? bus_if.spi_mosi : miso_val;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        csn_falls = 0;
        prev_csn  = 1'b1;
    end
    always @(negedge clk) begin
        if (prev_csn && !bus_if.spi_csn) csn_falls++;
        prev_csn = bus_if.spi_csn;
    end

    function automatic logic [31:0] mask_of(input int l);
        return (l == 31) ? 32'hFFFF_FFFF : ((32'd1 << (l + 1)) - 32'd1);
    endfunction

    function automatic logic [31:0] exp_read(input logic [15:0] hi, input logic [15:0] idx);
        if (hi != BASE) return 32'd0;
        case (idx)
            16'h0000: return in_m[0];
            16'h0001: return in_m[1];
            16'h0008: return out_m[0];
            16'h0009: return out_m[1];
            16'h0010: return cfg_m;
            16'h0011: return {31'd0, busy_m};
            16'h0012: return tx_m;
            16'h0013: return rx_m;
            default:  return 32'd0;
        endcase
    endfunction

    function automatic void model_write(input logic [15:0] hi, input logic [15:0] idx,
                                        input logic [31:0] data);
        if (hi != BASE) return;
        case (idx)
            16'h0008: out_m[0] = data;
            16'h0009: out_m[1] = data;
            16'h0010: if (!busy_m) cfg_m = data & 32'h0000_1FFF;
            16'h0012: tx_m = data;
            default:  ;
        endcase
    endfunction

    function automatic void model_reset();
        out_m[0] = 32'd0;
        out_m[1] = 32'd0;
        cfg_m    = 32'h0000_0704;
        tx_m     = 32'd0;
        rx_m     = 32'd0;
        busy_m   = 1'b0;
    endfunction

    task automatic drive_in();
        bus_if.in_ports = {in_m[1], in_m[0]};
    endtask

    task automatic wr(input logic [15:0] hi, input logic [15:0] idx,
                      input logic [31:0] data, output logic [31:0] rdv);
        @(negedge clk);
        bus_if.addr = {hi, idx};
        bus_if.din  = data;
        bus_if.mwe  = 1'b1;
        @(posedge clk);
        #1;
        rdv = bus_if.dout;
        bus_if.mwe = 1'b0;
    endtask

    task automatic rd(input logic [15:0] hi, input logic [15:0] idx, output logic [31:0] rdv);
        @(negedge clk);
        bus_if.addr = {hi, idx};
        bus_if.mwe  = 1'b0;
        @(posedge clk);
        #1;
        rdv = bus_if.dout;
    endtask

    // Runs one frame and measures it; comparisons happen in the callers.
    task automatic run_xfer(input int d, input int l, input logic [31:0] tx,
                            output int busy_len, output logic [31:0] mosi_w,
                            output int rises, output int perr, output logic to);
        logic [31:0] junk;
        logic        prev_sclk;
        int          c0;
        int          last_rise;
        int          n;
        wr(BASE, 16'h0010, {19'd0, 5'(l), 8'(d)}, junk);
        model_write(BASE, 16'h0010, {19'd0, 5'(l), 8'(d)});
        wr(BASE, 16'h0012, tx, junk);
        model_write(BASE, 16'h0012, tx);
        wr(BASE, 16'h0011, 32'd1, junk);
        c0        = cyc;
        prev_sclk = 1'b0;
        rises     = 0;
        mosi_w    = 32'd0;
        last_rise = -1;
        perr      = 0;
        n         = 0;
        while (bus_if.spi_busy && n < 3000) begin
            if (bus_if.spi_sclk && !prev_sclk) begin
                rises++;
                mosi_w = {mosi_w[30:0], bus_if.spi_mosi};
                if (last_rise >= 0 && (cyc - last_rise) != 2 * (d + 1)) perr++;
                last_rise = cyc;
            end
            prev_sclk = bus_if.spi_sclk;
            @(posedge clk);
            #1;
            n++;
        end
        to       = (n >= 3000);
        busy_len = cyc - c0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1;
        in_m[0] = $urandom;
        in_m[1] = $urandom;
        drive_in();
        bus_if.addr = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus_if.dout !== 32'd0) begin errors++; $display("FAIL rst_dout got %h exp 0", bus_if.dout); end
        checks++; if (bus_if.out_ports !== 64'd0) begin errors++; $display("FAIL rst_out_ports got %h exp 0", bus_if.out_ports); end
        checks++; if (bus_if.spi_csn !== 1'b1) begin errors++; $display("FAIL rst_csn got %b exp 1", bus_if.spi_csn); end
        checks++; if (bus_if.spi_sclk !== 1'b0) begin errors++; $display("FAIL rst_sclk got %b exp 0", bus_if.spi_sclk); end
        checks++; if (bus_if.spi_mosi !== 1'b0) begin errors++; $display("FAIL rst_mosi got %b exp 0", bus_if.spi_mosi); end
        checks++; if (bus_if.spi_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus_if.spi_busy); end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i <= 16'h13; i++) begin
            rd(BASE, 16'(i), v);
            checks++;
            if (v !== exp_read(BASE, 16'(i))) begin
                errors++;
                $display("FAIL rst_read idx %0h got %h exp %h", i, v, exp_read(BASE, 16'(i)));
            end
        end
    endtask

    task automatic test_out_regs();
        logic [31:0] v;
        wr(BASE, 16'h0009, 32'hDEAD_BEEF, v);
        model_write(BASE, 16'h0009, 32'hDEAD_BEEF);
        rd(BASE, 16'h0009, v);
        checks++; if (v !== 32'hDEAD_BEEF) begin errors++; $display("FAIL out1_read got %h exp deadbeef", v); end
        checks++; if (bus_if.out_ports[63:32] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL out1_pins got %h exp deadbeef", bus_if.out_ports[63:32]); end
        wr(16'h0001, 16'h0009, 32'h1111_1111, v);
        rd(BASE, 16'h0009, v);
        checks++; if (v !== 32'hDEAD_BEEF) begin errors++; $display("FAIL base_miss_write got %h exp deadbeef", v); end
        rd(16'h0001, 16'h0009, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL base_miss_read got %h exp 0", v); end
        // Read and write of the same register in one cycle returns old data.
        wr(BASE, 16'h0009, 32'hCAFE_F00D, v);
        checks++; if (v !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rdw_old got %h exp deadbeef", v); end
        model_write(BASE, 16'h0009, 32'hCAFE_F00D);
        checks++; if (bus_if.out_ports[63:32] !== 32'hCAFE_F00D) begin errors++; $display("FAIL rdw_new got %h exp cafef00d", bus_if.out_ports[63:32]); end
    endtask

    task automatic test_random_regs();
        logic [31:0] v;
        logic [31:0] data;
        logic [31:0] expv;
        logic [15:0] idx;
        logic [15:0] hi;
        for (int it = 0; it < 40; it++) begin
            idx = 16'($urandom_range(0, 23));
            if (idx == 16'h0011) idx = 16'h0014;
            hi   = ($urandom_range(0, 7) == 0) ? 16'h0002 : BASE;
            data = $urandom;
            in_m[$urandom_range(0, 1)] = $urandom;
            drive_in();
            expv = exp_read(hi, idx);
            if ($urandom_range(0, 1) == 1) begin
                wr(hi, idx, data, v);
                model_write(hi, idx, data);
            end else begin
                rd(hi, idx, v);
            end
            checks++;
            if (v !== expv) begin
                errors++;
                $display("FAIL rand_reg hi %h idx %h got %h exp %h", hi, idx, v, expv);
            end
        end
        checks++;
        if (bus_if.out_ports !== {out_m[1], out_m[0]}) begin
            errors++;
            $display("FAIL rand_out_pins got %h exp %h", bus_if.out_ports, {out_m[1], out_m[0]});
        end
    endtask

    task automatic check_frame(input string nm, input int d, input int l,
                               input int busy_len, input logic [31:0] mosi_w,
                               input logic [31:0] mosi_exp, input int rises,
                               input int perr, input logic to,
                               input logic [31:0] rx_exp);
        logic [31:0] v;
        checks++; if (to) begin errors++; $display("FAIL %s timeout busy stuck high", nm); end
        checks++; if (busy_len != (2 * (l + 1) + 2) * (d + 1)) begin errors++; $display("FAIL %s busy_len got %0d exp %0d", nm, busy_len, (2 * (l + 1) + 2) * (d + 1)); end
        checks++; if (rises != l + 1) begin errors++; $display("FAIL %s sclk_pulses got %0d exp %0d", nm, rises, l + 1); end
        checks++; if (perr != 0) begin errors++; $display("FAIL %s sclk_period bad %0d exp 0", nm, perr); end
        checks++; if (mosi_w !== mosi_exp) begin errors++; $display("FAIL %s mosi_bits got %h exp %h", nm, mosi_w, mosi_exp); end
        rx_m = rx_exp;
        rd(BASE, 16'h0013, v);
        checks++; if (v !== rx_exp) begin errors++; $display("FAIL %s rx got %h exp %h", nm, v, rx_exp); end
    endtask

    task automatic test_spi_a5();
        int bl, r, pe; logic [31:0] mw; logic to;
        loop_en = 1'b1;
        run_xfer(0, 7, 32'h0000_00A5, bl, mw, r, pe, to);
        check_frame("spi_a5", 0, 7, bl, mw, 32'h0000_00A5, r, pe, to, 32'h0000_00A5);
    endtask

    task automatic test_spi_ones();
        int bl, r, pe; logic [31:0] mw; logic to;
        loop_en  = 1'b0;
        miso_val = 1'b1;
        run_xfer(3, 31, 32'h1234_5678, bl, mw, r, pe, to);
        check_frame("spi_ones", 3, 31, bl, mw, 32'h1234_5678, r, pe, to, 32'hFFFF_FFFF);
        loop_en = 1'b1;
    endtask

    task automatic test_spi_random();
        int bl, r, pe, d, l; logic [31:0] mw, tx; logic to;
        loop_en = 1'b1;
        for (int it = 0; it < 5; it++) begin
            d  = $urandom_range(0, 2);
            l  = $urandom_range(0, 31);
            tx = $urandom;
            run_xfer(d, l, tx, bl, mw, r, pe, to);
            check_frame("spi_rand", d, l, bl, mw, tx & mask_of(l), r, pe, to, tx & mask_of(l));
        end
    endtask

    task automatic test_busy_collision();
        logic [31:0] v;
        int falls0, c0, n;
        loop_en = 1'b1;
        wr(BASE, 16'h0010, 32'h0000_0703, v);
        model_write(BASE, 16'h0010, 32'h0000_0703);
        wr(BASE, 16'h0012, 32'h0000_003C, v);
        model_write(BASE, 16'h0012, 32'h0000_003C);
        falls0 = csn_falls;
        wr(BASE, 16'h0011, 32'd1, v);
        c0 = cyc;
        busy_m = 1'b1;
        wr(BASE, 16'h0011, 32'd1, v);
        wr(BASE, 16'h0010, 32'h0000_0100, v);
        model_write(BASE, 16'h0010, 32'h0000_0100);
        wr(BASE, 16'h0012, 32'h0000_0077, v);
        model_write(BASE, 16'h0012, 32'h0000_0077);
        rd(BASE, 16'h0010, v);
        checks++; if (v !== 32'h0000_0703) begin errors++; $display("FAIL coll_cfg_kept got %h exp 00000703", v); end
        rd(BASE, 16'h0011, v);
        checks++; if (v !== 32'd1) begin errors++; $display("FAIL coll_start_read got %h exp 1", v); end
        n = 0;
        while (bus_if.spi_busy && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        busy_m = 1'b0;
        checks++; if (cyc - c0 != 72) begin errors++; $display("FAIL coll_busy_len got %0d exp 72", cyc - c0); end
        repeat (40) @(posedge clk);
        #1;
        checks++; if (csn_falls - falls0 != 1) begin errors++; $display("FAIL coll_csn_windows got %0d exp 1", csn_falls - falls0); end
        rd(BASE, 16'h0012, v);
        checks++; if (v !== 32'h0000_0077) begin errors++; $display("FAIL coll_tx_written got %h exp 00000077", v); end
        rx_m = 32'h0000_003C;
        rd(BASE, 16'h0013, v);
        checks++; if (v !== 32'h0000_003C) begin errors++; $display("FAIL coll_rx got %h exp 0000003c", v); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        logic prev_sclk;
        int rises, n, bl, r, pe;
        logic [31:0] mw;
        logic to;
        loop_en = 1'b1;
        wr(BASE, 16'h0010, 32'h0000_0F01, v);
        wr(BASE, 16'h0012, 32'h0000_BEEF, v);
        wr(BASE, 16'h0011, 32'd1, v);
        prev_sclk = 1'b0;
        rises = 0;
        n = 0;
        while (rises < 5 && n < 500) begin
            if (bus_if.spi_sclk && !prev_sclk) rises++;
            prev_sclk = bus_if.spi_sclk;
            if (rises < 5) begin
                @(posedge clk);
                #1;
            end
            n++;
        end
        checks++; if (rises != 5) begin errors++; $display("FAIL mid_rst_rises got %0d exp 5", rises); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus_if.spi_csn !== 1'b1) begin errors++; $display("FAIL mid_rst_csn got %b exp 1", bus_if.spi_csn); end
        checks++; if (bus_if.spi_sclk !== 1'b0) begin errors++; $display("FAIL mid_rst_sclk got %b exp 0", bus_if.spi_sclk); end
        checks++; if (bus_if.spi_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b exp 0", bus_if.spi_busy); end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        rd(BASE, 16'h0013, v);
        checks++; if (v !== 32'd0) begin errors++; $display("FAIL mid_rst_rx got %h exp 0", v); end
        rd(BASE, 16'h0010, v);
        checks++; if (v !== 32'h0000_0704) begin errors++; $display("FAIL mid_rst_cfg got %h exp 00000704", v); end
        run_xfer(4, 7, 32'h0000_0096, bl, mw, r, pe, to);
        check_frame("post_rst", 4, 7, bl, mw, 32'h0000_0096, r, pe, to, 32'h0000_0096);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        reset           = 1'b1;
        loop_en         = 1'b1;
        miso_val        = 1'b0;
        bus_if.addr     = 32'd0;
        bus_if.din      = 32'd0;
        bus_if.mwe      = 1'b0;
        bus_if.in_ports = 64'd0;
        model_reset();
        test_reset();
        test_out_regs();
        test_random_regs();
        test_spi_a5();
        test_spi_ones();
        test_spi_random();
        test_busy_collision();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
